// File: rtl/pattern_det_pkg.sv
// Shared constants, types and helpers for the parametrised serial pattern detector.
package pattern_det_pkg;

    localparam int DEF_PATTERN_W = 3;
    localparam int DEF_CNT_W     = 16;

    // Width needed to hold a fill count from 0 up to and including pw.
    function automatic int fill_w(input int pw);
        return $clog2(pw + 1);
    endfunction

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag raised on an increment at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         ovf
);

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/pattern_detector_param.sv
// Serial pattern detector with programmable pattern/mask, overlap mode, warm-up gating
// and a saturating match counter.
module pattern_detector_param
    import pattern_det_pkg::*;
#(
    parameter int PATTERN_W = DEF_PATTERN_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [PATTERN_W-1:0] cfg_mask,
    input  logic                 cfg_overlap,
    input  logic                 in_valid,
    input  logic                 data_in,
    output logic                 detected,
    output logic [CNT_W-1:0]     match_count,
    output logic                 count_ovf
);

    localparam int              FW   = fill_w(PATTERN_W);
    localparam logic [FW-1:0]   FULL = FW'(PATTERN_W);

    logic [PATTERN_W-1:0] shift_q, shift_d;
    logic [FW-1:0]        fill_q, fill_d, fill_inc;
    logic                 det_q, det_d;
    logic                 match;
    fill_state_e          state;

    // The fill count is the whole state machine; state is its decoded view.
    always_comb begin
        state = (fill_q == FULL) ? ARMED : FILL;
    end

    always_comb begin
        shift_d  = shift_q;
        fill_d   = fill_q;
        fill_inc = (state == ARMED) ? FULL : fill_q + FW'(1);
        match    = 1'b0;
        if (clear) begin
            shift_d = '0;
            fill_d  = '0;
        end else if (in_valid) begin
            shift_d = {shift_q[PATTERN_W-2:0], data_in};
            fill_d  = fill_inc;
            match   = (fill_inc == FULL) &&
                      (((shift_d ^ cfg_pattern) & cfg_mask) == '0);
            // Non-overlapping: stale history stays in shift_q but must be refilled.
            if (match && !cfg_overlap) begin
                fill_d = '0;
            end
        end
        det_d = match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (match),
        .count (match_count),
        .ovf   (count_ovf)
    );

    assign detected = det_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Table-driven bench for pattern_detector_param (PATTERN_W=3, CNT_W=2).
module tb_pattern_detector_param;

  localparam int PW = 3;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [PW-1:0] cfg_pattern;
  logic [PW-1:0] cfg_mask;
  logic          cfg_overlap;
  logic          in_valid;
  logic          data_in;
  logic          detected;
  logic [CW-1:0] match_count;
  logic          count_ovf;

  pattern_detector_param #(
    .PATTERN_W (PW),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .detected    (detected),
    .match_count (match_count),
    .count_ovf   (count_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            grp;
    logic          clr;
    logic          vld;
    logic          din;
    logic [PW-1:0] pat;
    logic [PW-1:0] msk;
    logic          ovl;
    logic          det;
    logic [CW-1:0] cnt;
    logic          ovf;
  } vec_t;

  vec_t vecs[$];
  logic [CW+1:0] exp_q[$];
  int n_vec;
  int n_miss;

  task automatic add(input int grp, input logic clr, input logic vld, input logic din,
                     input logic [PW-1:0] pat, input logic [PW-1:0] msk, input logic ovl,
                     input logic det, input logic [CW-1:0] cnt, input logic ovf);
    vec_t v;
    v.grp = grp; v.clr = clr; v.vld = vld; v.din = din;
    v.pat = pat; v.msk = msk; v.ovl = ovl;
    v.det = det; v.cnt = cnt; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [CW+1:0] act, input logic [CW+1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got det/cnt/ovf=%b required %b", name, act, exp);
    end
  endtask

  // driver: drive one cycle of inputs, push expectation, sample #1 after the edge
  task automatic apply(input vec_t v, input string name);
    logic [CW+1:0] e;
    clear       = v.clr;
    in_valid    = v.vld;
    data_in     = v.din;
    cfg_pattern = v.pat;
    cfg_mask    = v.msk;
    cfg_overlap = v.ovl;
    exp_q.push_back({v.det, v.cnt, v.ovf});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      compare(name, {detected, match_count, count_ovf}, e);
    end
  endtask

  task automatic bit_in(input logic din, input logic [PW-1:0] pat, input logic [PW-1:0] msk,
                        input logic det, input logic [CW-1:0] cnt, input logic ovf,
                        input string name);
    vec_t v;
    v.grp = 99; v.clr = 1'b0; v.vld = 1'b1; v.din = din;
    v.pat = pat; v.msk = msk; v.ovl = 1'b1;
    v.det = det; v.cnt = cnt; v.ovf = ovf;
    apply(v, name);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    data_in     = 1'b0;
    cfg_pattern = '0;
    cfg_mask    = '0;
    cfg_overlap = 1'b0;

    // 1: overlap, 101
    add(1, 0,1,1, 3'b101,3'b111,1, 0,2'd0,0);
    add(1, 0,1,0, 3'b101,3'b111,1, 0,2'd0,0);
    add(1, 0,1,1, 3'b101,3'b111,1, 1,2'd1,0);
    add(1, 0,1,0, 3'b101,3'b111,1, 0,2'd1,0);
    add(1, 0,1,1, 3'b101,3'b111,1, 1,2'd2,0);
    add(1, 1,0,0, 3'b101,3'b111,1, 0,2'd0,0);
    // 2: non-overlap, 101
    add(2, 0,1,1, 3'b101,3'b111,0, 0,2'd0,0);
    add(2, 0,1,0, 3'b101,3'b111,0, 0,2'd0,0);
    add(2, 0,1,1, 3'b101,3'b111,0, 1,2'd1,0);
    add(2, 0,1,0, 3'b101,3'b111,0, 0,2'd1,0);
    add(2, 0,1,1, 3'b101,3'b111,0, 0,2'd1,0);
    add(2, 0,1,0, 3'b101,3'b111,0, 0,2'd1,0);
    add(2, 0,1,1, 3'b101,3'b111,0, 1,2'd2,0);
    add(2, 1,0,0, 3'b101,3'b111,0, 0,2'd0,0);
    // 3a: warm-up, pattern 001
    add(3, 0,1,1, 3'b001,3'b111,1, 0,2'd0,0);
    add(3, 0,1,0, 3'b001,3'b111,1, 0,2'd0,0);
    add(3, 0,1,0, 3'b001,3'b111,1, 0,2'd0,0);
    add(3, 0,1,1, 3'b001,3'b111,1, 1,2'd1,0);
    add(3, 1,0,0, 3'b001,3'b111,1, 0,2'd0,0);
    // 3b: pattern 000 must not match on cleared history before fill completes
    add(3, 0,1,0, 3'b000,3'b111,1, 0,2'd0,0);
    add(3, 0,1,0, 3'b000,3'b111,1, 0,2'd0,0);
    add(3, 0,1,0, 3'b000,3'b111,1, 1,2'd1,0);
    add(3, 1,0,0, 3'b000,3'b111,1, 0,2'd0,0);
    // 3c: mask 101, pattern 101
    add(3, 0,1,1, 3'b101,3'b101,1, 0,2'd0,0);
    add(3, 0,1,1, 3'b101,3'b101,1, 0,2'd0,0);
    add(3, 0,1,1, 3'b101,3'b101,1, 1,2'd1,0);
    add(3, 0,1,1, 3'b101,3'b101,1, 1,2'd2,0);
    add(3, 0,1,0, 3'b101,3'b101,1, 0,2'd2,0);
    add(3, 1,0,0, 3'b101,3'b101,1, 0,2'd0,0);
    // 4: valid gaps, then clear beats a valid bit
    add(4, 0,1,1, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,0,1, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,0,0, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,0,1, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,1,0, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,1,1, 3'b101,3'b111,1, 1,2'd1,0);
    add(4, 0,0,1, 3'b101,3'b111,1, 0,2'd1,0);
    add(4, 1,1,1, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,1,0, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 0,1,1, 3'b101,3'b111,1, 0,2'd0,0);
    add(4, 1,0,0, 3'b101,3'b111,1, 0,2'd0,0);
    // 5: saturation with mask 000 (every armed bit matches)
    add(5, 0,1,1, 3'b000,3'b000,1, 0,2'd0,0);
    add(5, 0,1,0, 3'b000,3'b000,1, 0,2'd0,0);
    add(5, 0,1,1, 3'b000,3'b000,1, 1,2'd1,0);
    add(5, 0,1,0, 3'b000,3'b000,1, 1,2'd2,0);
    add(5, 0,1,1, 3'b000,3'b000,1, 1,2'd3,0);
    add(5, 0,1,1, 3'b000,3'b000,1, 1,2'd3,1);
    add(5, 0,1,0, 3'b000,3'b000,1, 1,2'd3,1);
    add(5, 0,0,0, 3'b000,3'b000,1, 0,2'd3,1);
    add(5, 1,0,0, 3'b000,3'b000,1, 0,2'd0,0);

    // asynchronous reset state, checked before the first clock edge
    #2;
    compare("reset_state", {detected, match_count, count_ovf}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d_grp%0d", i, vecs[i].grp));
    end

    // 6: async reset mid-stream while detected is high and the counter has overflowed
    bit_in(1'b1, 3'b000, 3'b000, 0, 2'd0, 0, "r6_b1");
    bit_in(1'b0, 3'b000, 3'b000, 0, 2'd0, 0, "r6_b2");
    bit_in(1'b1, 3'b000, 3'b000, 1, 2'd1, 0, "r6_b3");
    bit_in(1'b1, 3'b000, 3'b000, 1, 2'd2, 0, "r6_b4");
    bit_in(1'b1, 3'b000, 3'b000, 1, 2'd3, 0, "r6_b5");
    bit_in(1'b0, 3'b000, 3'b000, 1, 2'd3, 1, "r6_b6");
    #3;
    rst_n = 1'b0;
    #1;
    compare("async_reset_mid", {detected, match_count, count_ovf}, 4'b0000);
    #2;
    rst_n = 1'b1;
    bit_in(1'b1, 3'b000, 3'b000, 0, 2'd0, 0, "r6_refill1");
    bit_in(1'b1, 3'b000, 3'b000, 0, 2'd0, 0, "r6_refill2");
    bit_in(1'b1, 3'b000, 3'b000, 1, 2'd1, 0, "r6_refill3");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
